mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the instruction-fetch port (I, read-only)
//  and the load/store port (D, read/write, byte-masked). D carries the byte mask and read/write
//  strobes from the load/store controller; loaded words return raw for byte-lane extraction.
//  D has priority; a saturating starvation counter guarantees I forward progress.
// PARAMETERS
//  ADDR_W      30  word-address width (byte address [ADDR_W+1:2])
//  RD_LATENCY  1   RAM read latency in cycles, legal 1..2
//  STARVE_MAX  4   consecutive lost I cycles before I is forced ahead of D, legal 1..15
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  i_req      in   1       fetch read request
//  i_addr     in   ADDR_W  fetch word address
//  i_gnt      out  1       fetch request accepted this cycle
//  i_rvalid   out  1       i_rdata valid (one cycle)
//  i_rdata    out  32      fetch read data
//  d_req      in   1       data request (read or write)
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data word address
//  d_be       in   4       write byte enables (ignored for reads)
//  d_wdata    in   32      write data, pre-aligned to byte lanes
//  d_gnt      out  1       data request accepted this cycle
//  d_rvalid   out  1       d_rdata valid (one cycle, reads only)
//  d_rdata    out  32      data read word (raw, unextracted)
//  mem_en     out  1       RAM access strobe
//  mem_we     out  1       RAM write strobe
//  mem_addr   out  ADDR_W  RAM word address
//  mem_be     out  4       RAM byte enables
//  mem_wdata  out  32      RAM write data
//  mem_rdata  in   32      RAM read data, RD_LATENCY cycles after mem_en & !mem_we
// BEHAVIOUR
//  - Handshake: requester holds req and all fields stable until gnt. gnt is combinational from
//    req and state, same cycle. A granted read gets rvalid exactly RD_LATENCY cycles later.
//    Writes get no rvalid. Full throughput: one grant per cycle, reads pipelined.
//  - Arbitration per cycle, at most one grant:
//    d_req & !force_i -> D; i_req & (!d_req | force_i) -> I; force_i = (starve_cnt == STARVE_MAX).
//  - starve_cnt (4 bit): +1 when i_req & !i_gnt, saturating at STARVE_MAX; cleared on i_gnt or
//    !i_req. Dropping i_req forfeits accrued credit.
//  - RAM drive: mem_en = i_gnt | d_gnt; mem_we = d_gnt & d_we; mem_addr from winner;
//    mem_be = d_be on D write, 4'b1111 on any read, 4'b0000 idle; mem_wdata = d_wdata always.
//  - D write with d_be = 4'b0000 (misaligned store squashed upstream): granted normally,
//    mem_we = 1, mem_be = 0, RAM unchanged, no error raised.
//  - Return path: RD_LATENCY-deep shift register of {valid, owner}, loaded on each read grant.
//    At the tail, i_rvalid or d_rvalid pulses per owner. i_rdata = d_rdata = mem_rdata
//    (consumers qualify with rvalid). A return and a new grant in the same cycle are legal.
//  - Reset (any time): starve_cnt = 0, return pipeline cleared, i_gnt/d_gnt/mem_en/mem_we = 0
//    for the whole reset, all rvalid = 0. Reads in flight at reset never return.
//    Requesters reissue after reset.
//  - No FIFOs, no backpressure on rvalid: consumers must always accept returned data.
// TESTING
//  1 I-only: i_req held, i_addr 0,1,2 -> i_gnt each cycle; i_rvalid at +RD_LATENCY, data = RAM[0..2].
//  2 Contention, STARVE_MAX=4, both req held -> grant pattern D,D,D,D,I repeating;
//    starve_cnt 0->4->0.
//  3 D write word 3, d_be=4'b0100, d_wdata=0xAABBCCDD over RAM[3]=0 -> I read returns 0x00BB0000.
//  4 D write d_be=4'b0000 to word 5 (RAM[5]=0x12345678) -> mem_we=1, mem_be=0,
//    next read 0x12345678, no d_rvalid.
//  5 D read granted, rst asserted next cycle -> no rvalid ever;
//    all outputs 0 during reset; clean restart after.
//  6 Back-to-back D read word 1, I read word 2 -> d_rvalid then i_rvalid in consecutive cycles,
//    correct data, never both.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: load/store (D) wins over fetch (I), but a starvation
// counter forces I ahead once it has lost STARVE_MAX cycles in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]            starve_cnt;
  logic                  force_i;
  logic                  rd_issue;
  logic [RD_LATENCY:1]   vld_pipe;
  logic [RD_LATENCY:1]   own_pipe;  // 1 = read belongs to D

  // Grants are masked by rst so nothing reaches the RAM while reset is held.
  assign force_i  = (starve_cnt == STARVE_LIM);
  assign d_gnt    = !rst && d_req && !force_i;
  assign i_gnt    = !rst && i_req && (!d_req || force_i);
  assign rd_issue = i_gnt || (d_gnt && !d_we);

  assign mem_en    = i_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_wdata = d_wdata;

  always_comb begin
    mem_be = 4'b0000;
    if (mem_we)      mem_be = d_be;
    else if (mem_en) mem_be = 4'b1111;
  end

  // Credit is forfeited whenever I drops its request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  starve_cnt <= '0;
    else if (!i_req || i_gnt) starve_cnt <= '0;
    else if (!force_i)        starve_cnt <= starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      own_pipe[1] <= d_gnt;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        own_pipe[s] <= own_pipe[s-1];
      end
    end
  end

  assign i_rvalid = vld_pipe[RD_LATENCY] && !own_pipe[RD_LATENCY];
  assign d_rvalid = vld_pipe[RD_LATENCY] &&  own_pipe[RD_LATENCY];
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference model predicts grants and
// read returns; a separate monitor pops expected returns as rvalid appears.
module tb_mem_port_arbiter;
  localparam int AW = 30, LAT = 2, SMAX = 4, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [3:0]    d_be;
  logic [31:0]   d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .RD_LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] w, logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = w[8*b +: 8];
  endfunction

  // RAM environment: follows whatever the DUT drives on the mem_* bus.
  logic [31:0] ram [DEPTH];
  logic [31:0] rd_sr [LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr[3:0]] <= merge(ram[mem_addr[3:0]], mem_wdata, mem_be);
    if (mem_en && !mem_we) rd_sr[0] <= ram[mem_addr[3:0]];
    for (int k = 1; k < LAT; k++) rd_sr[k] <= rd_sr[k-1];
  end
  assign mem_rdata = rd_sr[LAT-1];

  // Reference model: arbitration rules and memory contents from the requester side.
  typedef struct { bit own_d; logic [31:0] data; int due; } exp_t;
  exp_t        expq[$];
  logic [31:0] ref_mem [DEPTH];
  int          lost = 0;
  bit          ei, ed;
  logic [3:0]  ea;
  logic [3:0]  xbe;

  always @(negedge clk) begin
    if (rst) begin
      lost = 0;
      tests++;
      if (i_gnt || d_gnt || mem_en || mem_we) begin
        fails++;
        $display("FAIL reset_quiet: i_gnt=%b d_gnt=%b mem_en=%b mem_we=%b, required all 0",
                 i_gnt, d_gnt, mem_en, mem_we);
      end
    end else begin
      ed = d_req && (lost < SMAX);
      ei = i_req && !ed;
      tests++;
      if (i_gnt !== ei || d_gnt !== ed) begin
        fails++;
        $display("FAIL grant @%0d: i_gnt=%b d_gnt=%b, required %b %b", cyc, i_gnt, d_gnt, ei, ed);
      end
      ea  = ed ? d_addr[3:0] : i_addr[3:0];
      xbe = (ed && d_we) ? d_be : ((ed || ei) ? 4'hF : 4'h0);
      tests++;
      if (mem_en !== (ed || ei) || mem_we !== (ed && d_we) || mem_be !== xbe ||
          mem_wdata !== d_wdata || ((ed || ei) && mem_addr[3:0] !== ea)) begin
        fails++;
        $display("FAIL mem_bus @%0d: en=%b we=%b be=%b addr=%h wdata=%h, required en=%b we=%b be=%b addr=%h wdata=%h",
                 cyc, mem_en, mem_we, mem_be, mem_addr, mem_wdata, ed || ei, ed && d_we, xbe, ea, d_wdata);
      end
      if (ed && d_we) ref_mem[ea] = merge(ref_mem[ea], d_wdata, d_be);
      else if (ed || ei) expq.push_back('{ed, ref_mem[ea], cyc + LAT});
      if (i_req && !ei) lost = (lost < SMAX) ? lost + 1 : SMAX;
      else              lost = 0;
    end
  end

  // Monitor: pops the scoreboard whenever a return is due or appears.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      tests++;
      if (i_rvalid || d_rvalid) begin
        fails++;
        $display("FAIL reset_rvalid: i_rvalid=%b d_rvalid=%b, required 0 0", i_rvalid, d_rvalid);
      end
    end else begin
      tests++;
      if (i_rvalid && d_rvalid) begin
        fails++;
        $display("FAIL both_rvalid @%0d: i_rvalid and d_rvalid both 1, required at most one", cyc);
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
        tests++;
        if ((expq[0].own_d ? !(d_rvalid && !i_rvalid) : !(i_rvalid && !d_rvalid)) ||
            (expq[0].own_d ? d_rdata : i_rdata) !== expq[0].data) begin
          fails++;
          $display("FAIL return @%0d: i_rvalid=%b d_rvalid=%b data=%h, required %s return data=%h",
                   cyc, i_rvalid, d_rvalid, expq[0].own_d ? d_rdata : i_rdata,
                   expq[0].own_d ? "D" : "I", expq[0].data);
        end
        void'(expq.pop_front());
      end else if (i_rvalid || d_rvalid) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid @%0d: i_rvalid=%b d_rvalid=%b, required none", cyc, i_rvalid, d_rvalid);
      end
    end
  end

  // Stimulus helpers
  bit gi, gd;
  task automatic tick();
    @(negedge clk); gi = i_gnt; gd = d_gnt;
    @(posedge clk); #1;
  endtask

  task automatic d_issue(input bit we, input int addr, input logic [3:0] be, input logic [31:0] wd);
    int g = 0;
    d_req = 1'b1; d_we = we; d_addr = AW'(addr); d_be = be; d_wdata = wd;
    do begin tick(); g++; end while (!gd && g < 20);
    d_req = 1'b0;
    tests++;
    if (!gd) begin fails++; $display("FAIL d_grant_timeout: no d_gnt in %0d cycles, required a grant", g); end
  endtask

  task automatic i_issue(input int addr);
    int g = 0;
    i_req = 1'b1; i_addr = AW'(addr);
    do begin tick(); g++; end while (!gi && g < 20);
    i_req = 1'b0;
    tests++;
    if (!gi) begin fails++; $display("FAIL i_grant_timeout: no i_gnt in %0d cycles, required a grant", g); end
  endtask

  task automatic wait_rv(input bit is_d, input string name, input logic [31:0] want);
    int g = 0;
    bit seen = 0;
    logic [31:0] got = 'x;
    while (!seen && g < 10) begin
      @(negedge clk); g++;
      if (is_d ? d_rvalid : i_rvalid) begin seen = 1; got = is_d ? d_rdata : i_rdata; end
    end
    @(posedge clk); #1;
    tests++;
    if (!seen || got !== want) begin
      fails++;
      $display("FAIL %s: rvalid_seen=%0b data=%h, required rvalid with data=%h", name, seen, got, want);
    end
  endtask

  initial begin
    int a, guard, td, ti, nrv;
    logic [9:0]  pat;
    logic [31:0] dv, iv, v;

    for (int i = 0; i < DEPTH; i++) begin v = $urandom; ram[i] = v; ref_mem[i] = v; end
    ram[3] = 32'h0;          ref_mem[3] = 32'h0;
    ram[5] = 32'h12345678;   ref_mem[5] = 32'h12345678;

    // Reset held with both requesters asserted: grants must stay masked.
    rst = 1'b1;
    i_req = 1'b1; i_addr = '0;
    d_req = 1'b1; d_we = 1'b1; d_addr = '0; d_be = 4'hF; d_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();

    // 1: I-only streaming reads of words 0..2
    a = 0; guard = 0;
    i_req = 1'b1; i_addr = AW'(0);
    while (a < 3 && guard < 20) begin
      tick(); guard++;
      if (gi) begin a++; i_addr = AW'(a); end
    end
    i_req = 1'b0;
    tests++;
    if (a != 3 || guard != 3) begin
      fails++; $display("FAIL i_stream: %0d grants in %0d cycles, required 3 in 3", a, guard);
    end
    repeat (LAT + 2) tick();

    // 2: sustained contention, grant pattern D,D,D,D,I repeating
    pat = '0;
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(7);
    i_req = 1'b1; i_addr = AW'(8);
    for (int n = 0; n < 10; n++) begin
      tick();
      pat = {pat[8:0], gd};
      if (gi) i_addr = AW'(9 + n % 4);
    end
    d_req = 1'b0; i_req = 1'b0;
    tests++;
    if (pat !== 10'b1111011110) begin
      fails++; $display("FAIL starve_pattern: D-grant bits=%b, required 1111011110", pat);
    end
    repeat (LAT + 2) tick();

    // 3: single-byte store then fetch of the same word
    d_issue(1'b1, 3, 4'b0100, 32'hAABBCCDD);
    i_issue(3);
    wait_rv(1'b0, "byte_store_read", 32'h00BB0000);

    // 4: squashed store (no byte enables) leaves the word untouched
    d_issue(1'b1, 5, 4'b0000, 32'hFFFFFFFF);
    d_issue(1'b0, 5, 4'b1111, 32'h0);
    wait_rv(1'b1, "null_store_read", 32'h12345678);

    // 5: reset right after a granted read; the read must never return
    d_issue(1'b0, 9, 4'b1111, 32'h0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    nrv = 0;
    for (int n = 0; n < 2 * LAT + 2; n++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid) nrv++;
    end
    @(posedge clk); #1;
    tests++;
    if (nrv != 0) begin fails++; $display("FAIL reset_flush: %0d rvalids after reset, required 0", nrv); end
    i_issue(2);
    wait_rv(1'b0, "post_reset_read", ref_mem[2]);

    // 6: D read and I read requested together -> back-to-back returns
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(1); d_be = 4'hF;
    i_req = 1'b1; i_addr = AW'(2);
    guard = 0;
    while ((d_req || i_req) && guard < 20) begin
      tick(); guard++;
      if (gd) d_req = 1'b0;
      if (gi) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    td = -1; ti = -1; dv = 'x; iv = 'x;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d_rvalid) begin td = k; dv = d_rdata; end
      if (i_rvalid) begin ti = k; iv = i_rdata; end
    end
    @(posedge clk); #1;
    tests++;
    if (td < 0 || ti != td + 1 || dv !== ref_mem[1] || iv !== ref_mem[2]) begin
      fails++;
      $display("FAIL b2b_returns: d at %0d data=%h, i at %0d data=%h, required i one cycle after d, data %h/%h",
               td, dv, ti, iv, ref_mem[1], ref_mem[2]);
    end

    // Randomized traffic with a mid-run reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) rst = 1'b1;
      if (n == 202) rst = 1'b0;
      tick();
      if (!i_req || gi) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      if (!d_req || gd) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = AW'($urandom_range(0, DEPTH - 1));
        d_be    = 4'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 3) tick();
    tests++;
    if (expq.size() != 0) begin
      fails++; $display("FAIL drain: %0d returns outstanding, required 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
